// File: rtl/nn_seq_pkg.sv
// Shared types for the dense-layer sequencer: FSM state encoding and index width helpers.
package nn_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        BIAS  = 3'd4,
        STORE = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Minimum width able to index n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Minimum width able to address a rows x cols weight block.
    function automatic int addr_width(input int rows, input int cols);
        return idx_width(rows * cols);
    endfunction

endpackage

// File: rtl/layer_sequencer_index_counter.sv
// Wrapping up-counter used for the row and column walks of the layer sequencer.
module index_counter #(
    parameter int WRAP  = 3,
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             increment,
    output logic [WIDTH-1:0] value,
    output logic             last_value
);

    logic [WIDTH-1:0] r_value;
    logic             w_last;

    assign w_last     = (r_value == WIDTH'(WRAP - 1));
    assign value      = r_value;
    assign last_value = w_last;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_value <= '0;
        end else if (increment) begin
            r_value <= w_last ? '0 : r_value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one ROWS x COLS matrix-vector pass over a shared MAC datapath.
// Optional bias stage between DRAIN and STORE is enabled by LAYER_SEQUENCER_BIAS_EN.
module layer_sequencer
    import nn_seq_pkg::*;
#(
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int ROW_W  = 2,
    parameter int COL_W  = 2,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic [ROW_W-1:0]  row_index,
    output logic [COL_W-1:0]  col_index,
    output logic [ADDR_W-1:0] weight_addr,
    output logic              acc_clear,
    output logic              mac_en,
    output logic              row_store,
`ifdef LAYER_SEQUENCER_BIAS_EN
    output logic              bias_add,
`endif
    output logic [ROW_W-1:0]  store_index
);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_acc_clear;
    logic             r_mac_en;
    logic             r_row_store;
    logic [ROW_W-1:0] r_store_idx;
`ifdef LAYER_SEQUENCER_BIAS_EN
    logic             r_bias_add;
`endif

    logic             w_issue;
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col;
    logic             w_row_last;
    logic             w_col_last;
    logic             w_row_clear;
    logic             w_col_clear;
    logic             w_row_inc;

    assign w_issue     = (r_state == MAC) && !hold;
    assign w_col_clear = clear || (r_state == IDLE);
    // Row is held at ROWS-1 through DONE and only returns to 0 on entry to IDLE.
    assign w_row_clear = clear || (r_state == IDLE) || (r_state == DONE);
    assign w_row_inc   = (r_state == STORE) && !w_row_last;

    index_counter #(.WRAP(ROWS), .WIDTH(ROW_W)) u_row_cnt (
        .clock      (clock),
        .clear      (w_row_clear),
        .increment  (w_row_inc),
        .value      (w_row),
        .last_value (w_row_last)
    );

    index_counter #(.WRAP(COLS), .WIDTH(COL_W)) u_col_cnt (
        .clock      (clock),
        .clear      (w_col_clear),
        .increment  (w_issue),
        .value      (w_col),
        .last_value (w_col_last)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_acc_clear <= 1'b0;
            r_mac_en    <= 1'b0;
            r_row_store <= 1'b0;
            r_store_idx <= '0;
`ifdef LAYER_SEQUENCER_BIAS_EN
            r_bias_add  <= 1'b0;
`endif
        end else begin
            // One-cycle ROM latency: the accumulate strobe trails the issue.
            r_mac_en    <= w_issue;
            r_done      <= 1'b0;
            r_acc_clear <= 1'b0;
            r_row_store <= 1'b0;
            r_store_idx <= '0;
`ifdef LAYER_SEQUENCER_BIAS_EN
            r_bias_add  <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= CLR;
                        r_busy      <= 1'b1;
                        r_acc_clear <= 1'b1;
                    end
                end
                CLR: r_state <= MAC;
                MAC: begin
                    if (w_issue && w_col_last) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
`ifdef LAYER_SEQUENCER_BIAS_EN
                    r_state     <= BIAS;
                    r_bias_add  <= 1'b1;
`else
                    r_state     <= STORE;
                    r_row_store <= 1'b1;
                    r_store_idx <= w_row;
`endif
                end
`ifdef LAYER_SEQUENCER_BIAS_EN
                BIAS: begin
                    r_state     <= STORE;
                    r_row_store <= 1'b1;
                    r_store_idx <= w_row;
                end
`endif
                STORE: begin
                    if (w_row_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= CLR;
                        r_acc_clear <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign acc_clear   = r_acc_clear;
    assign mac_en      = r_mac_en;
    assign row_store   = r_row_store;
    assign store_index = r_store_idx;
    assign row_index   = w_row;
    assign col_index   = w_col;
    assign weight_addr = ADDR_W'(w_row) * ADDR_W'(COLS) + ADDR_W'(w_col);
`ifdef LAYER_SEQUENCER_BIAS_EN
    assign bias_add    = r_bias_add;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: a 3x3 and a 1x1 instance share stimulus; a schedule model predicts every output.
module tb_layer_sequencer;

    localparam int NC  = 64;
    localparam int NS  = 10;
`ifdef LAYER_SEQUENCER_BIAS_EN
    localparam int BO  = 1;
`else
    localparam int BO  = 0;
`endif
    localparam int DNOM = 19 + 3 * BO;

    logic clk = 1'b0;
    logic clear = 1'b1;
    logic start = 1'b0;
    logic hold  = 1'b0;

    logic       busy0, done0, accc0, mac0, rst0;
    logic [1:0] row0, col0, sidx0;
    logic [3:0] addr0;
    logic       busy1, done1, accc1, mac1, rst1;
    logic [0:0] row1, col1, sidx1, addr1;
    logic       bias0, bias1;

    always #5 clk = ~clk;

    layer_sequencer #(.ROWS(3), .COLS(3), .ROW_W(2), .COL_W(2), .ADDR_W(4)) dut (
        .clock(clk), .clear(clear), .start(start), .hold(hold),
        .busy(busy0), .done(done0), .row_index(row0), .col_index(col0),
        .weight_addr(addr0), .acc_clear(accc0), .mac_en(mac0), .row_store(rst0),
`ifdef LAYER_SEQUENCER_BIAS_EN
        .bias_add(bias0),
`endif
        .store_index(sidx0)
    );

    layer_sequencer #(.ROWS(1), .COLS(1), .ROW_W(1), .COL_W(1), .ADDR_W(1)) dut_small (
        .clock(clk), .clear(clear), .start(start), .hold(hold),
        .busy(busy1), .done(done1), .row_index(row1), .col_index(col1),
        .weight_addr(addr1), .acc_clear(accc1), .mac_en(mac1), .row_store(rst1),
`ifdef LAYER_SEQUENCER_BIAS_EN
        .bias_add(bias1),
`endif
        .store_index(sidx1)
    );

`ifndef LAYER_SEQUENCER_BIAS_EN
    assign bias0 = 1'b0;
    assign bias1 = 1'b0;
`endif

    int exp_v [2][NC][NS];
    int obs_v [2][NC][NS];
    bit st_v [NC];
    bit hd_v [NC];
    bit cl_v [NC];
    int ncyc;
    int errors = 0;
    int checks = 0;
    string sig_name [NS] = '{"busy", "done", "row", "col", "addr",
                             "acc_clear", "mac_en", "row_store", "store_index", "bias_add"};

    task automatic setv(int d, int t, int s, int v);
        if (t < NC) exp_v[d][t][s] = v;
    endtask

    task automatic mark(int d, int t, int r, int c, int cols);
        setv(d, t, 0, 1);
        setv(d, t, 2, r);
        setv(d, t, 3, c);
        setv(d, t, 4, r * cols + c);
    endtask

    // Expected timeline of one pass started by a start sampled at cycle s.
    task automatic gen_pass(int d, int s, int rows, int cols, output int t_done);
        int t;
        t = s + 1;
        for (int r = 0; r < rows; r++) begin
            mark(d, t, r, 0, cols); setv(d, t, 5, 1); t++;
            for (int c = 0; c < cols; c++) begin
                while (t < NC && hd_v[t]) begin
                    mark(d, t, r, c, cols); t++;
                end
                mark(d, t, r, c, cols); setv(d, t + 1, 6, 1); t++;
            end
            mark(d, t, r, 0, cols); t++;
            if (BO == 1) begin
                mark(d, t, r, 0, cols); setv(d, t, 9, 1); t++;
            end
            mark(d, t, r, 0, cols); setv(d, t, 7, 1); setv(d, t, 8, r); t++;
        end
        mark(d, t, rows - 1, 0, cols); setv(d, t, 1, 1);
        t_done = t;
    endtask

    task automatic build_model(int d, int rows, int cols);
        int free_from;
        int td;
        free_from = 0;
        for (int t = 0; t < NC; t++)
            for (int s = 0; s < NS; s++) exp_v[d][t][s] = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (cl_v[k]) begin
                for (int j = k + 1; j < NC; j++)
                    for (int s = 0; s < NS; s++) exp_v[d][j][s] = 0;
                free_from = k + 1;
            end else if (k >= free_from && st_v[k]) begin
                gen_pass(d, k, rows, cols, td);
                free_from = td + 1;
            end
        end
    endtask

    task automatic set_stim(int sc);
        for (int k = 0; k < NC; k++) begin
            st_v[k] = 1'b0; hd_v[k] = 1'b0; cl_v[k] = 1'b0;
        end
        case (sc)
            0: begin ncyc = 26; st_v[0] = 1'b1; end
            1: begin ncyc = 28; st_v[0] = 1'b1; hd_v[3] = 1'b1; hd_v[4] = 1'b1; end
            2: begin
                ncyc = 2 * DNOM + 4;
                st_v[0] = 1'b1; st_v[5] = 1'b1; st_v[DNOM] = 1'b1; st_v[DNOM + 1] = 1'b1;
            end
            default: begin
                ncyc = 36 + 3 * BO;
                st_v[0] = 1'b1; cl_v[10] = 1'b1; st_v[12] = 1'b1;
            end
        endcase
    endtask

    task automatic sample(int k);
        obs_v[0][k] = '{int'(busy0), int'(done0), int'(row0), int'(col0), int'(addr0),
                        int'(accc0), int'(mac0), int'(rst0), int'(sidx0), int'(bias0)};
        obs_v[1][k] = '{int'(busy1), int'(done1), int'(row1), int'(col1), int'(addr1),
                        int'(accc1), int'(mac1), int'(rst1), int'(sidx1), int'(bias1)};
    endtask

    task automatic lit(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic run_scenario(int sc);
        set_stim(sc);
        build_model(0, 3, 3);
        build_model(1, 1, 1);
        @(posedge clk); #1;
        clear = 1'b1; start = 1'b0; hold = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            clear = cl_v[k]; start = st_v[k]; hold = hd_v[k];
            @(negedge clk);
            sample(k);
            for (int d = 0; d < 2; d++) begin
                for (int s = 0; s < NS; s++) begin
                    checks++;
                    if (obs_v[d][k][s] != exp_v[d][k][s]) begin
                        errors++;
                        $display("FAIL s%0d dut%0d cyc %0d %s got=%0d exp=%0d",
                                 sc, d, k, sig_name[s], obs_v[d][k][s], exp_v[d][k][s]);
                    end
                end
                if (obs_v[d][k][7] != 0)
                    $display("s%0d dut%0d cyc %0d row_store idx=%0d", sc, d, k, obs_v[d][k][8]);
                if (obs_v[d][k][1] != 0)
                    $display("s%0d dut%0d cyc %0d done", sc, d, k);
            end
        end
    endtask

    initial begin
        int cnt;

        run_scenario(0);
        lit("nom_acc_clear@1", obs_v[0][1][5], 1);
        lit("nom_addr@2", obs_v[0][2][4], 0);
        lit("nom_addr@4", obs_v[0][4][4], 2);
        lit("nom_mac_en@3", obs_v[0][3][6], 1);
        lit("nom_row_store", obs_v[0][6 + BO][7], 1);
        lit("nom_row1_addr", obs_v[0][8 + BO][4], 3);
        lit("nom_done", obs_v[0][DNOM][1], 1);
        lit("nom_idle_after", obs_v[0][DNOM + 1][0], 0);
        lit("small_mac_en@3", obs_v[1][3][6], 1);
        lit("small_row_store", obs_v[1][4 + BO][7], 1);
        lit("small_done", obs_v[1][5 + BO][1], 1);

        run_scenario(1);
        cnt = 0;
        for (int k = 0; k < ncyc; k++) cnt += obs_v[0][k][6];
        lit("hold_mac_en_total", cnt, 9);
        lit("hold_addr@5", obs_v[0][5][4], 1);
        lit("hold_mac_en@4", obs_v[0][4][6], 0);
        lit("hold_done", obs_v[0][DNOM + 2][1], 1);

        run_scenario(2);
        cnt = 0;
        for (int k = 0; k < ncyc; k++) cnt += obs_v[0][k][1];
        lit("start_done_count", cnt, 2);
        lit("start_restart_done", obs_v[0][2 * DNOM + 1][1], 1);

        run_scenario(3);
        lit("clear_busy@11", obs_v[0][11][0], 0);
        lit("clear_mac_en@11", obs_v[0][11][6], 0);
        lit("clear_done", obs_v[0][12 + DNOM][1], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
